// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types for the instruction-cache fill controller: FSM state encoding
// and default geometry with the offset/index/tag width helpers.
package rvga_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } fill_state_t;

    localparam int DEF_NUM_SETS       = 4;
    localparam int DEF_LINES_PER_SET  = 16;
    localparam int DEF_BEAT_WIDTH     = 64;
    localparam int DEF_BEATS_PER_LINE = 4;

    // Byte-offset bits inside one cache line.
    function automatic int off_width(input int beat_width, input int beats_per_line);
        return $clog2((beat_width * beats_per_line) / 8);
    endfunction

    function automatic int idx_width(input int lines_per_set);
        return $clog2(lines_per_set);
    endfunction

    function automatic int tag_width(input int beat_width, input int beats_per_line,
                                     input int lines_per_set);
        return 32 - off_width(beat_width, beats_per_line) - idx_width(lines_per_set);
    endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Beat-indexed line assembly register for cache fills; beat 0 lands in the
// lowest bits and the counter wraps after the last beat of a line.
module icache_line_buffer
    import rvga_types::*;
#(
    parameter int beat_width     = DEF_BEAT_WIDTH,
    parameter int beats_per_line = DEF_BEATS_PER_LINE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic [beat_width-1:0]                rdata,
    output logic [beat_width*beats_per_line-1:0] line,
    output logic                                 last_beat
);

    localparam int CNT_W = $clog2(beats_per_line);

    logic [CNT_W-1:0] cnt;

    assign last_beat = (cnt == CNT_W'(beats_per_line - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            line <= '0;
        end else if (load) begin
            line[int'(cnt) * beat_width +: beat_width] <= rdata;
            cnt <= last_beat ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/fill controller: answers hits, bursts a line from pmem
// on a miss and writes it into the chosen victim way. ICACHE_INVALID_FIRST_EN
// makes an invalid way preferred over the NMRU choice as victim.
module icache_fill_ctrl
    import rvga_types::*;
#(
    parameter int  num_sets       = DEF_NUM_SETS,
    parameter int  lines_per_set  = DEF_LINES_PER_SET,
    parameter int  beat_width     = DEF_BEAT_WIDTH,
    parameter int  beats_per_line = DEF_BEATS_PER_LINE,
    localparam int OFF_W  = off_width(beat_width, beats_per_line),
    localparam int IDX_W  = idx_width(lines_per_set),
    localparam int TAG_W  = tag_width(beat_width, beats_per_line, lines_per_set),
    localparam int LINE_W = beat_width * beats_per_line
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_read,
    input  logic [31:0]           cpu_addr,
    output logic                  cpu_resp,
    input  logic [num_sets-1:0]   hit_vector,
    input  logic [num_sets-1:0]   valid_vector,
    input  logic [num_sets-1:0]   icache_replacement_select,
    output logic                  icache_replacement_update,
    output logic [num_sets-1:0]   mru_hit_vector,
    output logic [IDX_W-1:0]      index,
    output logic [num_sets-1:0]   way_load,
    output logic [TAG_W-1:0]      fill_tag,
    output logic [LINE_W-1:0]     fill_data,
    output logic                  pmem_read,
    output logic [31:0]           pmem_addr,
    input  logic                  pmem_resp,
    input  logic [beat_width-1:0] pmem_rdata
);

    fill_state_t state, next_state;

    logic [31-OFF_W:0]   line_addr;
    logic [num_sets-1:0] victim;
    logic [num_sets-1:0] victim_sel;
    logic                beat_load;
    logic                last_beat;
    logic [LINE_W-1:0]   line;
    logic                unused_bits;

    function automatic logic [num_sets-1:0] lowest_bit(input logic [num_sets-1:0] v);
        return v & (~v + num_sets'(1));
    endfunction

    // A broken (zero or multi-hot) NMRU choice degrades to its lowest bit, or way 0.
    always_comb begin
        victim_sel = (icache_replacement_select == '0) ? num_sets'(1)
                                                       : lowest_bit(icache_replacement_select);
`ifdef ICACHE_INVALID_FIRST_EN
        if (valid_vector != '1)
            victim_sel = lowest_bit(~valid_vector);
`endif
    end

`ifdef ICACHE_INVALID_FIRST_EN
    assign unused_bits = ^cpu_addr[OFF_W-1:0];
`else
    assign unused_bits = ^{cpu_addr[OFF_W-1:0], valid_vector};
`endif

    assign beat_load = (state == MISS) && pmem_resp;

    icache_line_buffer #(
        .beat_width     (beat_width),
        .beats_per_line (beats_per_line)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (beat_load),
        .rdata     (pmem_rdata),
        .line      (line),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            line_addr <= '0;
            victim    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && cpu_read && hit_vector == '0) begin
                line_addr <= cpu_addr[31:OFF_W];
                victim    <= victim_sel;
            end
        end
    end

    always_comb begin
        next_state                = state;
        cpu_resp                  = 1'b0;
        icache_replacement_update = 1'b0;
        mru_hit_vector            = '0;
        index                     = line_addr[IDX_W-1:0];
        way_load                  = '0;
        fill_tag                  = '0;
        fill_data                 = '0;
        pmem_read                 = 1'b0;
        pmem_addr                 = '0;
        case (state)
            IDLE: begin
                index = cpu_addr[OFF_W +: IDX_W];
                if (cpu_read) begin
                    if (hit_vector != '0) begin
                        cpu_resp                  = 1'b1;
                        icache_replacement_update = 1'b1;
                        mru_hit_vector            = lowest_bit(hit_vector);
                    end else begin
                        next_state = MISS;
                    end
                end
            end
            MISS: begin
                pmem_read = 1'b1;
                pmem_addr = {line_addr, {OFF_W{1'b0}}};
                if (pmem_resp && last_beat)
                    next_state = FILL;
            end
            FILL: begin
                way_load                  = victim;
                fill_tag                  = line_addr[31-OFF_W:IDX_W];
                fill_data                 = line;
                icache_replacement_update = 1'b1;
                mru_hit_vector            = victim;
                next_state                = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: a cycle-by-cycle vector table plus
// hand-written reset-during-miss and fill sequences.
module tb_icache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_read;
    logic [31:0]  cpu_addr;
    logic         cpu_resp;
    logic [3:0]   hit_vector;
    logic [3:0]   valid_vector;
    logic [3:0]   icache_replacement_select;
    logic         icache_replacement_update;
    logic [3:0]   mru_hit_vector;
    logic [3:0]   index;
    logic [3:0]   way_load;
    logic [22:0]  fill_tag;
    logic [255:0] fill_data;
    logic         pmem_read;
    logic [31:0]  pmem_addr;
    logic         pmem_resp;
    logic [63:0]  pmem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         rd;
        logic [31:0]  addr;
        logic [3:0]   hit;
        logic [3:0]   valid;
        logic [3:0]   sel;
        logic         presp;
        logic [63:0]  pdata;
        logic         e_resp;
        logic         e_upd;
        logic [3:0]   e_mru;
        logic [3:0]   e_idx;
        logic [3:0]   e_wl;
        logic         e_pread;
        logic [31:0]  e_paddr;
        logic [22:0]  e_tag;
        logic [255:0] e_data;
    } vec_t;

    vec_t vecs[$];

`ifdef ICACHE_INVALID_FIRST_EN
    localparam logic [3:0] INV_VICT = 4'b0100;
`else
    localparam logic [3:0] INV_VICT = 4'b0001;
`endif

    localparam logic [31:0] ADDR_A = 32'h0000_1040;
    localparam logic [31:0] ADDR_B = 32'h0000_2064;
    localparam logic [31:0] ADDR_C = 32'h0000_3000;
    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] A0 = 64'hA0A0_A0A0_A0A0_A0A0;
    localparam logic [63:0] A1 = 64'hA1A1_A1A1_A1A1_A1A1;
    localparam logic [63:0] A2 = 64'hA2A2_A2A2_A2A2_A2A2;
    localparam logic [63:0] A3 = 64'hA3A3_A3A3_A3A3_A3A3;
    localparam logic [63:0] E0 = 64'hE000_0000_0000_00E0;
    localparam logic [63:0] E1 = 64'hE100_0000_0000_00E1;
    localparam logic [63:0] E2 = 64'hE200_0000_0000_00E2;
    localparam logic [63:0] E3 = 64'hE300_0000_0000_00E3;

    icache_fill_ctrl dut (
        .clk                       (clk),
        .rst                       (rst),
        .cpu_read                  (cpu_read),
        .cpu_addr                  (cpu_addr),
        .cpu_resp                  (cpu_resp),
        .hit_vector                (hit_vector),
        .valid_vector              (valid_vector),
        .icache_replacement_select (icache_replacement_select),
        .icache_replacement_update (icache_replacement_update),
        .mru_hit_vector            (mru_hit_vector),
        .index                     (index),
        .way_load                  (way_load),
        .fill_tag                  (fill_tag),
        .fill_data                 (fill_data),
        .pmem_read                 (pmem_read),
        .pmem_addr                 (pmem_addr),
        .pmem_resp                 (pmem_resp),
        .pmem_rdata                (pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic apply_stimulus(input logic r, input logic rd, input logic [31:0] addr,
                                  input logic [3:0] hit, input logic [3:0] valid,
                                  input logic [3:0] sel, input logic presp,
                                  input logic [63:0] pdata);
        @(negedge clk);
        rst                       = r;
        cpu_read                  = rd;
        cpu_addr                  = addr;
        hit_vector                = hit;
        valid_vector              = valid;
        icache_replacement_select = sel;
        pmem_resp                 = presp;
        pmem_rdata                = pdata;
        #1;
    endtask

    task automatic check_output(input int n, input vec_t v);
        check($sformatf("v%0d cpu_resp", n),  cpu_resp,                  v.e_resp);
        check($sformatf("v%0d update", n),    icache_replacement_update, v.e_upd);
        check($sformatf("v%0d mru", n),       mru_hit_vector,            v.e_mru);
        check($sformatf("v%0d index", n),     index,                     v.e_idx);
        check($sformatf("v%0d way_load", n),  way_load,                  v.e_wl);
        check($sformatf("v%0d pmem_read", n), pmem_read,                 v.e_pread);
        check($sformatf("v%0d pmem_addr", n), pmem_addr,                 v.e_paddr);
        check($sformatf("v%0d fill_tag", n),  fill_tag,                  v.e_tag);
        check($sformatf("v%0d fill_data", n), fill_data,                 v.e_data);
    endtask

    task automatic add_vec(input logic rd, input logic [31:0] addr, input logic [3:0] hit,
                           input logic [3:0] valid, input logic [3:0] sel, input logic presp,
                           input logic [63:0] pdata, input logic e_resp, input logic e_upd,
                           input logic [3:0] e_mru, input logic [3:0] e_idx,
                           input logic [3:0] e_wl, input logic e_pread,
                           input logic [31:0] e_paddr, input logic [22:0] e_tag,
                           input logic [255:0] e_data);
        vec_t v;
        v = '{rd, addr, hit, valid, sel, presp, pdata, e_resp, e_upd, e_mru, e_idx,
              e_wl, e_pread, e_paddr, e_tag, e_data};
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; cpu_read = 1'b0; cpu_addr = '0; hit_vector = '0;
        valid_vector = 4'hF; icache_replacement_select = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;

        // Reset state, hits (including multi-hit), then a miss with gapped beats
        // while cpu_addr/cpu_read wander, FILL with a stray beat, and the final hit.
        add_vec(0, 32'h0, 4'b0000, 4'hF, 4'b0000, 0, 64'h0,  0, 0, 4'b0000, 4'd0, 4'b0000, 0, 32'h0,    23'h0,  256'h0);
        add_vec(1, ADDR_A, 4'b0100, 4'hF, 4'b0000, 0, 64'h0, 1, 1, 4'b0100, 4'd2, 4'b0000, 0, 32'h0,    23'h0,  256'h0);
        add_vec(1, ADDR_A, 4'b0110, 4'hF, 4'b0000, 0, 64'h0, 1, 1, 4'b0010, 4'd2, 4'b0000, 0, 32'h0,    23'h0,  256'h0);
        add_vec(1, ADDR_B, 4'b0000, 4'hF, 4'b0010, 0, 64'h0, 0, 0, 4'b0000, 4'd3, 4'b0000, 0, 32'h0,    23'h0,  256'h0);
        add_vec(1, ADDR_B, 4'b0100, 4'hF, 4'b1000, 0, 64'h0, 0, 0, 4'b0000, 4'd3, 4'b0000, 1, 32'h2060, 23'h0,  256'h0);
        add_vec(1, ADDR_C, 4'b0100, 4'hF, 4'b0000, 1, B1,    0, 0, 4'b0000, 4'd3, 4'b0000, 1, 32'h2060, 23'h0,  256'h0);
        add_vec(0, ADDR_C, 4'b0000, 4'hF, 4'b0000, 0, 64'h0, 0, 0, 4'b0000, 4'd3, 4'b0000, 1, 32'h2060, 23'h0,  256'h0);
        add_vec(0, ADDR_C, 4'b0000, 4'hF, 4'b0000, 1, B2,    0, 0, 4'b0000, 4'd3, 4'b0000, 1, 32'h2060, 23'h0,  256'h0);
        add_vec(1, ADDR_C, 4'b0000, 4'hF, 4'b0000, 1, B3,    0, 0, 4'b0000, 4'd3, 4'b0000, 1, 32'h2060, 23'h0,  256'h0);
        add_vec(1, ADDR_C, 4'b0000, 4'hF, 4'b0000, 0, 64'h0, 0, 0, 4'b0000, 4'd3, 4'b0000, 1, 32'h2060, 23'h0,  256'h0);
        add_vec(1, ADDR_C, 4'b0000, 4'hF, 4'b0000, 1, B4,    0, 0, 4'b0000, 4'd3, 4'b0000, 1, 32'h2060, 23'h0,  256'h0);
        add_vec(1, ADDR_C, 4'b0001, 4'hF, 4'b0000, 1, 64'hDEAD_BEEF_DEAD_BEEF,
                0, 1, 4'b0010, 4'd3, 4'b0010, 0, 32'h0, 23'h10, {B4, B3, B2, B1});
        add_vec(1, ADDR_B, 4'b0010, 4'hF, 4'b0000, 0, 64'h0, 1, 1, 4'b0010, 4'd3, 4'b0000, 0, 32'h0,    23'h0,  256'h0);
        add_vec(0, 32'h0, 4'b0000, 4'hF, 4'b0000, 1, 64'h5555_5555_5555_5555,
                0, 0, 4'b0000, 4'd0, 4'b0000, 0, 32'h0, 23'h0, 256'h0);
        // Second miss: invalid-way victim choice and back-to-back beats.
        add_vec(1, ADDR_A, 4'b0000, 4'b1011, 4'b0001, 0, 64'h0, 0, 0, 4'b0000, 4'd2, 4'b0000, 0, 32'h0, 23'h0, 256'h0);
        add_vec(1, ADDR_A, 4'b0000, 4'hF, 4'b0000, 1, A0,    0, 0, 4'b0000, 4'd2, 4'b0000, 1, 32'h1040, 23'h0, 256'h0);
        add_vec(1, ADDR_A, 4'b0000, 4'hF, 4'b0000, 1, A1,    0, 0, 4'b0000, 4'd2, 4'b0000, 1, 32'h1040, 23'h0, 256'h0);
        add_vec(1, ADDR_A, 4'b0000, 4'hF, 4'b0000, 1, A2,    0, 0, 4'b0000, 4'd2, 4'b0000, 1, 32'h1040, 23'h0, 256'h0);
        add_vec(1, ADDR_A, 4'b0000, 4'hF, 4'b0000, 1, A3,    0, 0, 4'b0000, 4'd2, 4'b0000, 1, 32'h1040, 23'h0, 256'h0);
        add_vec(1, ADDR_A, 4'b0000, 4'hF, 4'b0000, 0, 64'h0,
                0, 1, INV_VICT, 4'd2, INV_VICT, 0, 32'h0, 23'h8, {A3, A2, A1, A0});
        add_vec(1, ADDR_A, INV_VICT, 4'hF, 4'b0000, 0, 64'h0, 1, 1, INV_VICT, 4'd2, 4'b0000, 0, 32'h0, 23'h0, 256'h0);

        apply_stimulus(1, 0, 32'h0, 4'b0000, 4'hF, 4'b0000, 0, 64'h0);
        apply_stimulus(1, 0, 32'h0, 4'b0000, 4'hF, 4'b0000, 0, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(0, vecs[i].rd, vecs[i].addr, vecs[i].hit, vecs[i].valid,
                           vecs[i].sel, vecs[i].presp, vecs[i].pdata);
            check_output(i, vecs[i]);
        end

        // Reset in the middle of a miss, after two beats have arrived.
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0100, 0, 64'h0);
        check("rm enter resp", cpu_resp, 1'b0);
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 1, B1);
        check("rm beat1 pread", pmem_read, 1'b1);
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 1, B2);
        check("rm beat2 pread", pmem_read, 1'b1);
        apply_stimulus(1, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 0, 64'h0);
        apply_stimulus(0, 0, ADDR_B, 4'b0000, 4'hF, 4'b0000, 1, B3);
        check("rm post pread", pmem_read, 1'b0);
        check("rm post way_load", way_load, 4'b0000);
        check("rm post update", icache_replacement_update, 1'b0);
        check("rm post fill_data", fill_data, 256'h0);
        apply_stimulus(0, 1, ADDR_A, 4'b0001, 4'hF, 4'b0000, 0, 64'h0);
        check("rm idle hit", cpu_resp, 1'b1);

        // Fresh miss with a zero NMRU select: way 0, and a full four beats needed.
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 0, 64'h0);
        check("m3 enter resp", cpu_resp, 1'b0);
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 1, E0);
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 1, E1);
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 1, E2);
        check("m3 beat3 way_load", way_load, 4'b0000);
        check("m3 beat3 pread", pmem_read, 1'b1);
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 1, E3);
        check("m3 beat4 pread", pmem_read, 1'b1);
        apply_stimulus(0, 1, ADDR_B, 4'b0000, 4'hF, 4'b0000, 0, 64'h0);
        check("m3 fill way_load", way_load, 4'b0001);
        check("m3 fill data", fill_data, {E3, E2, E1, E0});
        check("m3 fill tag", fill_tag, 23'h10);
        check("m3 fill pread", pmem_read, 1'b0);
        check("m3 fill resp", cpu_resp, 1'b0);
        apply_stimulus(0, 1, ADDR_B, 4'b0001, 4'hF, 4'b0000, 0, 64'h0);
        check("m3 idle resp", cpu_resp, 1'b1);
        check("m3 idle way_load", way_load, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
Miss/fill controller for the set-associative instruction cache.
- Decodes CPU fetch addresses and answers hits.
- On a miss, issues a burst read to physical memory and assembles the line in a local buffer.
- Writes the line into the victim way chosen by the NMRU replacement unit, then updates that unit.
- Sits between the fetch stage, the tag/data/valid arrays and the pmem port.

Parameters:
num_sets, 4, number of ways (one-hot vectors are num_sets wide)
lines_per_set, 16, lines per way; index width = clog2(lines_per_set)
beat_width, 64, pmem data bits per beat
beats_per_line, 4, beats per cache line; line width = beat_width*beats_per_line

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_read  in  1  fetch request, held until cpu_resp
cpu_addr  in  32  byte address of fetch
cpu_resp  out  1  fetch complete (hit this cycle)
hit_vector  in  num_sets  per-way tag match AND valid, from tag arrays
valid_vector  in  num_sets  per-way valid bits at index
icache_replacement_select  in  num_sets  one-hot NMRU victim
icache_replacement_update  out  1  load strobe for the NMRU array
mru_hit_vector  out  num_sets  one-hot way to record as MRU
index  out  clog2(lines_per_set)  array index (live or latched)
way_load  out  num_sets  one-hot tag/data/valid write enable
fill_tag  out  32-idx-off bits  tag to write
fill_data  out  beat_width*beats_per_line  assembled line
pmem_read  out  1  burst read request
pmem_addr  out  32  line-aligned burst address
pmem_resp  in  1  one beat valid
pmem_rdata  in  beat_width  beat data

Behaviour:
- Address split: off = clog2(line bytes), idx = clog2(lines_per_set), tag = upper bits.
- States: IDLE, MISS, FILL. Reset (sync, rst=1 at posedge) -> IDLE.
- Reset values: every output 0. Beat counter 0. Line buffer 0.
- IDLE:
  - index = cpu_addr index field.
  - If cpu_read and hit_vector != 0: cpu_resp = 1 combinationally in the same cycle. icache_replacement_update = 1. mru_hit_vector = hit_vector (lowest set bit only, if several bits are set).
  - If cpu_read and hit_vector == 0: latch line address (cpu_addr with offset zeroed) and victim, then go to MISS. cpu_resp stays 0.
  - Victim = icache_replacement_select. If that vector is 0 or not one-hot, the lowest set bit is used, or way 0 if it is 0.
- MISS:
  - pmem_read = 1 and pmem_addr = latched line address, held until the final beat.
  - Each pmem_resp writes pmem_rdata into buffer slot beat_cnt (beat 0 = lowest bits) and increments beat_cnt.
  - On the beat where beat_cnt == beats_per_line-1: go to FILL and clear beat_cnt (wrap). pmem_read drops the following cycle.
- FILL (exactly 1 cycle):
  - way_load = victim; fill_tag and fill_data driven; index = latched index.
  - icache_replacement_update = 1 with mru_hit_vector = victim.
  - Next state IDLE. The held request then hits there, so cpu_resp asserts.
- Miss latency, first cycle of request to cpu_resp: 1 + N beat-arrival cycles + 1 (FILL) + 1 (IDLE hit).
- Boundaries:
  - cpu_addr or cpu_read changing during MISS/FILL is ignored; the fill completes using the latched values.
  - pmem_resp in IDLE or FILL is ignored.
  - rst in MISS: return to IDLE next cycle, pmem_read deasserted, partial line discarded, no way_load.
  - cpu_resp is never asserted outside IDLE.
  - way_load and cpu_resp are never asserted in the same cycle.

Optional Feature:
- Macro ICACHE_INVALID_FIRST_EN.
- Defined: victim = lowest way with valid_vector bit 0, if any exists; otherwise icache_replacement_select.
- Undefined: valid_vector is unused and the victim always comes from icache_replacement_select.

Decomposition:
- Shared package (rvga_types): fill-controller state enum (IDLE, MISS, FILL) and offset/index/tag width helper constants.
- One natural sub-module: icache_line_buffer, which holds the beat counter and beat-indexed line register and signals the last beat.

Test Plan:
- Hit: valid way2 tag match, cpu_read addr 0x0000_1040 -> cpu_resp same cycle, index 2, update=1, mru_hit_vector 0100.
- Miss, 4 beats: addr 0x0000_2064, select 0010; beats 0x11..,0x22..,0x33..,0x44.. with gaps -> pmem_addr 0x0000_2060; FILL way_load 0010, fill_data {44,33,22,11}; cpu_resp one cycle after FILL.
- Back-to-back beats (pmem_resp 4 consecutive cycles) -> FILL on the cycle after beat 4; pmem_read low in FILL.
- Address change mid-miss: cpu_addr switched to 0x0000_3000 during MISS -> pmem_addr and fill_tag keep 0x0000_2060 values.
- Reset after beat 2 -> IDLE, pmem_read 0, no way_load; stray pmem_resp next cycle ignored.
- ICACHE_INVALID_FIRST_EN: valid_vector 1011, select 0001 -> way_load 0100; undefined -> way_load 0001.
